// File: rtl/ray_inv_dir_gen_if.sv
// Shared vector types and the request/result bundle of ray_inv_dir_gen.
// Vector component 0 = x, 1 = y, 2 = z.
package ray_inv_dir_pkg;
    typedef logic [2:0][31:0] vec3;        // signed Q16.16 per component
    typedef logic [2:0][35:0] vec3_18_18;  // signed Q18.18 per component
endpackage

interface ray_inv_dir_gen_if;
    import ray_inv_dir_pkg::*;

    logic      in_valid;
    logic      in_ready;
    vec3       ray_orig;
    vec3       ray_dir;
    logic      stall;
    logic      out_valid;
    vec3       ray_orig_out;
    vec3_18_18 inv_ray_dir;
    logic [2:0] div_by_zero;

    modport master (
        output in_valid, ray_orig, ray_dir, stall,
        input  in_ready, out_valid, ray_orig_out, inv_ray_dir, div_by_zero
    );

    modport slave (
        input  in_valid, ray_orig, ray_dir, stall,
        output in_ready, out_valid, ray_orig_out, inv_ray_dir, div_by_zero
    );
endinterface

// File: rtl/ray_inv_dir_gen.sv
// Ray setup: per-axis reciprocal direction (2^34 / |d|, Q18.18) via three restoring dividers.
// Optional build macro INV_DIR_DUAL_STEP_EN retires two quotient bits per cycle.
module ray_inv_dir_gen
    import ray_inv_dir_pkg::*;
(
    input logic               clk,
    input logic               rst_n,
    ray_inv_dir_gen_if.slave  bus
);

`ifdef INV_DIR_DUAL_STEP_EN
    localparam logic [5:0] LAST_ITER = 6'd17;
`else
    localparam logic [5:0] LAST_ITER = 6'd34;
`endif
    // One extra DIVIDE cycle after the last step applies the sign and zero bypass.
    localparam logic [5:0] FINAL_ITER = LAST_ITER + 6'd1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DIVIDE = 2'd1,
        DONE   = 2'd2
    } state_t;

    typedef struct packed {
        logic [31:0] rem;
        logic        qbit;
    } step_t;

    state_t state;
    state_t state_nxt;
    logic [5:0] iter;

    vec3             orig_q;
    logic [2:0][31:0] mag;
    logic [2:0]       neg;
    logic [2:0]       zero;
    logic [2:0][31:0] rem;
    logic [2:0][35:0] quo;
    logic [2:0][31:0] rem_nxt;
    logic [2:0][35:0] quo_nxt;

    vec3_18_18  inv_q;
    logic [2:0] dbz_q;
    vec3        orig_out_q;

    // Remainder is always below mag (<= 2^31), so the shifted trial needs 33 bits.
    function automatic step_t div_step(input logic [31:0] r, input logic din,
                                       input logic [31:0] m);
        logic [32:0] trial;
        step_t       res;
        trial = {r, din};
        if (trial >= {1'b0, m}) begin
            trial    = trial - {1'b0, m};
            res.qbit = 1'b1;
        end else begin
            res.qbit = 1'b0;
        end
        res.rem = trial[31:0];
        return res;
    endfunction

    // The dividend is 2^34: its only set bit is consumed on the very first step.
`ifdef INV_DIR_DUAL_STEP_EN
    step_t s_hi [3];
    step_t s_lo [3];

    always_comb begin
        for (int a = 0; a < 3; a++) begin
            s_hi[a]    = div_step(rem[a], 1'b0, mag[a]);
            s_lo[a]    = div_step(s_hi[a].rem, iter == 6'd0, mag[a]);
            rem_nxt[a] = s_lo[a].rem;
            quo_nxt[a] = {quo[a][33:0], s_hi[a].qbit, s_lo[a].qbit};
        end
    end
`else
    step_t s_one [3];

    // NOTE: combinational logic uses blocking '=' and assigns every output on every path, so no latch is inferred.
    always_comb begin
        for (int a = 0; a < 3; a++) begin
            s_one[a]   = div_step(rem[a], iter == 6'd0, mag[a]);
            rem_nxt[a] = s_one[a].rem;
            quo_nxt[a] = {quo[a][34:0], s_one[a].qbit};
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.in_valid)        state_nxt = DIVIDE;
            DIVIDE:  if (iter == FINAL_ITER)  state_nxt = DONE;
            DONE:    if (!bus.stall)          state_nxt = IDLE;
            default:                          state_nxt = IDLE;
        endcase
    end

    // NOTE: registered state uses non-blocking '<=' so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            iter       <= '0;
            orig_q     <= '0;
            mag        <= '0;
            neg        <= '0;
            zero       <= '0;
            rem        <= '0;
            quo        <= '0;
            inv_q      <= '0;
            dbz_q      <= '0;
            orig_out_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        orig_q <= bus.ray_orig;
                        iter   <= '0;
                        for (int a = 0; a < 3; a++) begin
                            neg[a]  <= bus.ray_dir[a][31];
                            zero[a] <= (bus.ray_dir[a] == 32'd0);
                            // Two's-complement negate; -2^31 maps to unsigned 2^31.
                            mag[a]  <= bus.ray_dir[a][31] ? (~bus.ray_dir[a] + 32'd1)
                                                          : bus.ray_dir[a];
                            rem[a]  <= '0;
                            quo[a]  <= '0;
                        end
                    end
                end
                DIVIDE: begin
                    if (iter == FINAL_ITER) begin
                        for (int a = 0; a < 3; a++) begin
                            inv_q[a] <= zero[a] ? 36'd0
                                      : (neg[a] ? (~quo[a] + 36'd1) : quo[a]);
                        end
                        dbz_q      <= zero;
                        orig_out_q <= orig_q;
                    end else begin
                        rem  <= rem_nxt;
                        quo  <= quo_nxt;
                        iter <= iter + 6'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.in_ready     = rst_n && (state == IDLE);
    assign bus.out_valid    = (state == DONE);
    assign bus.inv_ray_dir  = inv_q;
    assign bus.div_by_zero  = dbz_q;
    assign bus.ray_orig_out = orig_out_q;

endmodule

// File: doc/ray_inv_dir_gen.md
# ray_inv_dir_gen

Ray-setup stage that feeds `ray_bbox_intersect`. It accepts a ray origin and direction, then computes the per-axis reciprocal direction `inv_ray_dir` (Q18.18) and the `div_by_zero` flags using three parallel iterative restoring dividers. It presents the origin alongside the results, and holds them under the same `stall` convention the intersect stage uses.

## Interface
Parameters: none. All widths are fixed by the `vec3` / `vec3_18_18` types in `data_macros.sv`.
- `vec3` component: signed 32-bit Q16.16.
- `vec3_18_18` component: signed 36-bit Q18.18.

Ports:
- `clk` input 1: the only clock.
- `rst_n` input 1: reset, synchronous, active-low.
- `in_valid` input 1: ray request valid.
- `in_ready` output 1: block can accept a request.
- `ray_orig` input `vec3`: ray origin, captured on accept.
- `ray_dir` input `vec3`: ray direction, captured on accept.
- `stall` input 1: downstream stall; while high, a completed result is held.
- `out_valid` output 1: result valid.
- `ray_orig_out` output `vec3`: captured origin.
- `inv_ray_dir` output `vec3_18_18`: reciprocal direction.
- `div_by_zero` output 3: per-axis zero-direction flag. Bit 0 = x, bit 1 = y, bit 2 = z.

## Operation
- **State machine:** IDLE → DIVIDE → DONE → IDLE.
- **IDLE**
  - `in_ready = 1` (gated by `rst_n` high).
  - An edge with `in_valid` high captures `ray_orig` and `ray_dir`, loads the dividers and clears the iteration counter. The state moves to DIVIDE.
- **Per-axis setup at accept**
  - `neg = d[31]`.
  - `mag = |d|` as a 32-bit unsigned value. `-2^31` gives magnitude `2^31`.
  - Dividend is the constant `2^34` (1.0 in Q16.16 reciprocated into Q18.18).
- **DIVIDE**
  - Each cycle performs one restoring step per axis: shift the remainder in with the next dividend bit, subtract `mag` if the remainder is ≥ `mag`, and shift the quotient bit in.
  - The counter runs 0..34, giving 35 quotient bits.
  - After the last step the state moves to DONE.
- **Result**
  - Quotient = `floor(2^34 / mag)`, truncated toward zero. It is negated when `neg` is set, and is always within signed 36-bit range.
  - If `d == 0`, the divider for that axis is bypassed: its `div_by_zero` bit is 1 and its `inv_ray_dir` component is 0.
- **DONE**
  - `out_valid = 1`; `inv_ray_dir`, `div_by_zero` and `ray_orig_out` are registered and stable.
  - While `stall = 1` the state stays in DONE and nothing changes.
  - When `stall = 0` the result is consumed on that edge and the state returns to IDLE.
- **Handshake**
  - `in_ready` is 0 in DIVIDE and DONE; `in_valid` is ignored there.
  - There is one ray in flight, with no buffering.
- **Output hold:** outside DONE, the data outputs keep their last value and `out_valid = 0`.

## Timing
- **Reset values** (any edge with `rst_n = 0`, including mid-DIVIDE or DONE): state IDLE, `out_valid = 0`, `inv_ray_dir = 0`, `div_by_zero = 0`, `ray_orig_out = 0`, counter 0. An in-flight ray is discarded.
- **Handshake edges:** accept at edge N; the state is DIVIDE from N to N+35; `out_valid` rises after edge N+36.
- **Minimum throughput:** with `stall = 0`, one ray per 37 cycles. `in_ready` returns high the cycle after consumption.
- **Stall:**
  - `stall` has no effect in IDLE or DIVIDE; the division keeps running.
  - A stall asserted in the same cycle `out_valid` first rises holds the result.
- **Simultaneous events:** reset wins over accept and over consumption.

## Configuration
- `INV_DIR_DUAL_STEP_EN`
  - **Defined:** two restoring steps per cycle. The counter runs 0..17, giving 36 quotient bits; the extra leading bit is always 0. `out_valid` rises after edge N+19, for a throughput of 1 ray per 20 cycles.
  - **Undefined:** one step per cycle, with the latency above.
  - Results are bit-identical in both builds.

## Test plan
- **Unit and zero axes.** `ray_dir = (0x00010000, 0, 0)`, origin `vec3_default`.
  - Required: `inv_ray_dir = (0x000040000, 0, 0)`, `div_by_zero = 3'b110`, `ray_orig_out = vec3_default`.
  - `out_valid` rises exactly 36 edges after accept.
- **Mixed signs.** `ray_dir = (0x00020000, -0x00008000, 0x00004000)`.
  - Required: `inv = (0x000020000, -0x000080000, 0x000100000)`, i.e. (0.5, −2.0, 4.0), with `div_by_zero = 3'b000`.
- **Extremes.** `ray_dir = (1, 3, -2^31)`.
  - Required: `inv.x = 0x400000000`, `inv.y = 0x155555555` (truncated), `inv.z = -8`.
- **Stall hold.** Hold `stall = 1` for 5 cycles after `out_valid` rises.
  - Required: outputs stable, `in_ready = 0`.
  - After release: `out_valid = 0` and `in_ready = 1` on the next cycle. A second ray is accepted and completes correctly.
- **Reset mid-operation.** Assert `rst_n = 0` for one edge at DIVIDE iteration 10.
  - Required: all outputs 0 on the next cycle and `in_ready = 1` after release. A new ray `(0x00010000, 0x00010000, 0x00010000)` yields `inv = 0x000040000` on all axes with `div_by_zero = 0`.
- **Macro build.** Define `INV_DIR_DUAL_STEP_EN` and rerun the first three scenarios.
  - Required: identical values, with `out_valid` 19 edges after accept.
